// File: rtl/xor16_arbiter.sv
// Round-robin arbiter sharing one XOR16 datapath among NREQ requesters, with a one-entry tagged result slot.
// Optional macro XOR16_ARB_PARITY_EN adds a registered rsp_parity output.
module xor16_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_data,
    output logic [IDW-1:0]      rsp_id
`ifdef XOR16_ARB_PARITY_EN
    ,
    output logic                rsp_parity
`endif
);

    typedef enum logic {EMPTY, FULL} slotState_t;

    slotState_t       slotState;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grantIdx;
    logic [IDW-1:0]   scanIdx;
    logic             grantFound;
    logic             slotFree;
    logic             transfer;
    logic [W-1:0]     xorResult;

    assign rsp_valid = (slotState == FULL);
    assign slotFree  = (slotState == EMPTY) || rsp_ready;

    // Scan downward so the last hit kept is the one closest to ptr.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        scanIdx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scanIdx = IDW'((int'(ptr) + k) % NREQ);
            if (req_valid[scanIdx]) begin
                grantFound = 1'b1;
                grantIdx   = scanIdx;
            end
        end
    end

    assign transfer  = grantFound && slotFree && !rst;
    assign xorResult = req_a[int'(grantIdx)*W +: W] ^ req_b[int'(grantIdx)*W +: W];

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    // Pointer moves only on a transfer, so a stalled slot cannot starve anyone.
    always_ff @(posedge clk) begin
        if (rst) begin
            slotState  <= EMPTY;
            ptr        <= '0;
            rsp_data   <= '0;
            rsp_id     <= '0;
`ifdef XOR16_ARB_PARITY_EN
            rsp_parity <= 1'b0;
`endif
        end else if (transfer) begin
            slotState  <= FULL;
            rsp_data   <= xorResult;
            rsp_id     <= grantIdx;
`ifdef XOR16_ARB_PARITY_EN
            rsp_parity <= ^xorResult;
`endif
            if (int'(grantIdx) == NREQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grantIdx + 1'b1;
            end
        end else if (slotState == FULL && rsp_ready) begin
            slotState <= EMPTY;
        end
    end

endmodule

// File: tb/tb_xor16_arbiter.sv
// Self-checking bench for xor16_arbiter: directed scenarios plus random traffic against a behavioural model.
// Honours XOR16_ARB_PARITY_EN when the design is built with it.
module tb_xor16_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [W-1:0]        rsp_data;
    logic [IDW-1:0]      rsp_id;
`ifdef XOR16_ARB_PARITY_EN
    logic                rsp_parity;
`endif

    logic [W-1:0] aOp [NREQ];
    logic [W-1:0] bOp [NREQ];

    int checks = 0;
    int errors = 0;

    // Behavioural model of the result slot and the round-robin pointer.
    bit        mValid;
    int        mData;
    int        mId;
    int        mPtr;

    xor16_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef XOR16_ARB_PARITY_EN
        ,
        .rsp_parity(rsp_parity)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = aOp[i];
            req_b[i*W +: W] = bOp[i];
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // First valid requester found when walking upward from the pointer, wrapping around.
    function automatic int modelGrant(input logic [NREQ-1:0] valid);
        for (int k = 0; k < NREQ; k++) begin
            if (valid[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int popParity(input int value);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += (value >> i) & 1;
        return ones % 2;
    endfunction

    task automatic checkOutput(input logic [NREQ-1:0] valid, input logic rr, input logic r);
        int g;
        int expReady;
        g = modelGrant(valid);
        expReady = (!r && (!mValid || rr) && g >= 0) ? (1 << g) : 0;
        checkEq("req_ready", 32'(req_ready), 32'(expReady));
        checkEq("rsp_valid", 32'(rsp_valid), 32'(mValid));
        checkEq("rsp_data", 32'(rsp_data), 32'(mData));
        checkEq("rsp_id", 32'(rsp_id), 32'(mId));
`ifdef XOR16_ARB_PARITY_EN
        checkEq("rsp_parity", 32'(rsp_parity), 32'(popParity(mData)));
`endif
    endtask

    // Drive one cycle's inputs at negedge, check mid-cycle, then advance the model across the edge.
    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rr, input logic r);
        int g;
        req_valid = valid;
        rsp_ready = rr;
        rst       = r;
        #1;
        checkOutput(valid, rr, r);
        g = modelGrant(valid);
        if (r) begin
            mValid = 0; mData = 0; mId = 0; mPtr = 0;
        end else if (g >= 0 && (!mValid || rr)) begin
            mValid = 1;
            mData  = int'(aOp[g] ^ bOp[g]);
            mId    = g;
            mPtr   = (g + 1) % NREQ;
        end else if (mValid && rr) begin
            mValid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expectResult(input string tag, input int id, input int data);
        #1;
        checkEq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        checkEq({tag, "_id"}, 32'(rsp_id), 32'(id));
        checkEq({tag, "_data"}, 32'(rsp_data), 32'(data));
    endtask

    initial begin
        int fairIds [6];
        fairIds = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < NREQ; i++) begin
            aOp[i] = '0;
            bOp[i] = '0;
        end
        mValid = 0; mData = 0; mId = 0; mPtr = 0;
        req_valid = '0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        $display("[TB] reset and idle");
        applyStimulus(4'b1111, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) applyStimulus(4'b0000, 1'b1, 1'b0);

        $display("[TB] single request");
        aOp[2] = 16'hFFFF;
        bOp[2] = 16'h0F0F;
`ifdef XOR16_ARB_PARITY_EN
        #1;
        checkEq("single_ready_pre", 32'(req_ready), 32'd0);
`endif
        applyStimulus(4'b0100, 1'b1, 1'b0);
        expectResult("single", 2, 16'hF0F0);
`ifdef XOR16_ARB_PARITY_EN
        checkEq("single_parity", 32'(rsp_parity), 32'd0);
`endif

        $display("[TB] fairness");
        applyStimulus(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < NREQ; i++) begin
            aOp[i] = W'(i);
            bOp[i] = 16'h1000;
        end
        for (int s = 0; s < 6; s++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0);
            expectResult("fair", fairIds[s], 16'h1000 ^ fairIds[s]);
        end

        $display("[TB] backpressure");
        for (int s = 0; s < 3; s++) begin
            applyStimulus(4'b1111, 1'b0, 1'b0);
            expectResult("stall", 1, 16'h1001);
        end
        applyStimulus(4'b1111, 1'b1, 1'b0);
        expectResult("after_stall", 2, 16'h1002);

        $display("[TB] wrap");
        applyStimulus(4'b1001, 1'b1, 1'b0);
        expectResult("wrap_first", 3, 16'h1003);
        applyStimulus(4'b1001, 1'b1, 1'b0);
        expectResult("wrap_second", 0, 16'h1000);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        expectResult("wrap_ptr", 1, 16'h1001);

        $display("[TB] reset mid-operation");
        applyStimulus(4'b1111, 1'b1, 1'b0);
        expectResult("pre_reset", 2, 16'h1002);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        #1;
        checkEq("post_reset_valid", 32'(rsp_valid), 32'd0);
        checkEq("post_reset_id", 32'(rsp_id), 32'd0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        expectResult("post_reset_grant", 0, 16'h1000);

        $display("[TB] random traffic");
        for (int s = 0; s < 300; s++) begin
            for (int i = 0; i < NREQ; i++) begin
                aOp[i] = W'($urandom);
                bOp[i] = W'($urandom);
            end
            applyStimulus(NREQ'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 31) == 0));
        end
        applyStimulus(4'b0000, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
